// File: rtl/rcvbuf_ctrl.sv
// Receive-buffer sequencer: gates an external WIDTH-long shift chain, counts
// bits per frame and captures the chain into a held, handshaked output word.
module rcvbuf_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_stb,
  input  logic             sof,
  input  logic [WIDTH-1:0] par_in,
  output logic             shift_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frm_err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    CAPT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frm_err_q, frm_err_d;

  logic             start;
  logic             load;
  state_e           start_state;
  logic [CW-1:0]    start_cnt;

  assign start = bit_stb & sof;

  // A one-bit frame is complete on its sof strobe, so it skips RECV entirely.
  assign start_state = (WIDTH == 1) ? CAPT : RECV;
  assign start_cnt   = (WIDTH == 1) ? '0 : CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frm_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = start_state;
          cnt_d   = start_cnt;
        end
      end
      RECV: begin
        if (start) begin
          state_d   = start_state;
          cnt_d     = start_cnt;
          frm_err_d = 1'b1;
        end else if (bit_stb) begin
          if (cnt_q == LAST_CNT) begin
            state_d = CAPT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CAPT: begin
        if (start) begin
          state_d = start_state;
          cnt_d   = start_cnt;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture in CAPT samples par_in before any shift enabled in the same cycle.
  always_comb begin
    load      = (state_q == CAPT) & (~valid_q | out_ready);
    word_d    = load ? par_in : word_q;
    valid_d   = load | (valid_q & ~out_ready);
    overrun_d = (state_q == CAPT) & valid_q & ~out_ready;
  end

  always_comb begin
    shift_en   = ~rst & bit_stb & ((state_q == RECV) | sof);
    busy       = (state_q != IDLE);
    word_out   = word_q;
    word_valid = valid_q;
    overrun    = overrun_q;
    frm_err    = frm_err_q;
  end

endmodule
